// File: rtl/mips_pc_sequencer_if.sv
// Bundle of control, fetch and decode-side signals around the PC sequencer.
// The sequencer uses the master view; its environment uses the slave view.
interface mips_pc_sequencer_if;
    logic [1:0]  sm5;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] jr_addr;
    logic        halt;
    logic        instr_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        align_err;
    logic [31:0] retired;

    modport master (
        input  sm5, imm16, target26, jr_addr, halt, instr_ack,
        input  imem_ready, imem_rdata,
        output imem_req, imem_addr, instr, instr_valid,
        output pc, pc_plus4, align_err, retired
    );

    modport slave (
        output sm5, imm16, target26, jr_addr, halt, instr_ack,
        output imem_ready, imem_rdata,
        input  imem_req, imem_addr, instr, instr_valid,
        input  pc, pc_plus4, align_err, retired
    );
endinterface

// File: rtl/mips_pc_sequencer.sv
// Program-counter and instruction-fetch sequencer for the MIPS core.
//
//  state  | meaning
//  FETCH  | request the word at pc until memory returns it
//  EXEC   | hold instr/pc for the datapath until instr_ack
//  HALTED | no fetching; pc holds the next address; exit only by reset
module mips_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_pc_sequencer_if.master       bus
);

    typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        jr_misaligned;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_off    = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign jr_misaligned = (bus.jr_addr[1:0] != 2'b00);

    // Next-PC selection from the control unit's sm5 code.
    always_comb begin
        next_pc = pc_plus4;
        case (bus.sm5)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + branch_off;
            2'b10: next_pc = {pc_plus4[31:28], bus.target26, 2'b00};
            2'b11: next_pc = {bus.jr_addr[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= FETCH;
            pc_q            <= RESET_PC;
            bus.imem_addr   <= RESET_PC;
            bus.imem_req    <= 1'b0;
            bus.instr       <= 32'd0;
            bus.instr_valid <= 1'b0;
            bus.align_err   <= 1'b0;
            bus.retired     <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (!bus.imem_req) begin
                        // first cycle after reset: start the request at pc
                        bus.imem_req  <= 1'b1;
                        bus.imem_addr <= pc_q;
                    end else if (bus.imem_ready) begin
                        bus.instr       <= bus.imem_rdata;
                        bus.instr_valid <= 1'b1;
                        bus.imem_req    <= 1'b0;
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.instr_ack) begin
                        pc_q            <= next_pc;
                        bus.retired     <= bus.retired + 32'd1;
                        bus.instr_valid <= 1'b0;
                        if (bus.sm5 == 2'b11 && jr_misaligned) begin
                            bus.align_err <= 1'b1;
                        end
                        if (bus.halt) begin
                            state <= HALTED;
                        end else begin
                            // no bubble: the next request goes out right away
                            state         <= FETCH;
                            bus.imem_req  <= 1'b1;
                            bus.imem_addr <= next_pc;
                        end
                    end
                end
                HALTED: begin
                    bus.imem_req    <= 1'b0;
                    bus.instr_valid <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed bench for mips_pc_sequencer with a behavioural reference model
// and a per-cycle comparison of all outputs.
module tb_mips_pc_sequencer;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] SALT  = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_pc_sequencer_if bus();

    mips_pc_sequencer #(.RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // memory returns a word derived from the requested address
    assign bus.imem_rdata = bus.imem_addr ^ SALT;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_instr, m_ret;
    bit          m_req, m_valid, m_halted, m_align;

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [1:0] sel,
                                               input logic [15:0] imm, input logic [25:0] tgt,
                                               input logic [31:0] jr);
        int          off;
        logic [31:0] r;
        case (sel)
            2'd0:    r = p + 32'd4;
            2'd1:    begin off = $signed(imm); r = p + 32'd4 + 32'(off * 4); end
            2'd2:    r = ((p + 32'd4) & 32'hF000_0000) | (32'(tgt) * 32'd4);
            default: r = jr & 32'hFFFF_FFFC;
        endcase
        return r;
    endfunction

    // Model update: what must happen on each edge, from the block's rules.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = RPC; m_instr = 0; m_ret = 0;
            m_req = 0; m_valid = 0; m_halted = 0; m_align = 0;
        end else if (m_valid && bus.instr_ack) begin
            if (bus.sm5 == 2'd3 && (bus.jr_addr % 4) != 0) m_align = 1;
            m_pc     = model_next(m_pc, bus.sm5, bus.imm16, bus.target26, bus.jr_addr);
            m_ret    = m_ret + 1;
            m_valid  = 0;
            m_req    = !bus.halt;
            m_halted = bus.halt;
        end else if (m_req && bus.imem_ready) begin
            m_instr = m_pc ^ SALT;
            m_valid = 1;
            m_req   = 0;
        end else if (!m_req && !m_valid && !m_halted) begin
            m_req = 1;
        end
    end

    // Compare DUT against model on every falling edge.
    always @(negedge clk) begin
        chk("cmp_req", {31'd0, bus.imem_req}, {31'd0, m_req});
        if (m_req) chk("cmp_addr", bus.imem_addr, m_pc);
        chk("cmp_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
        if (m_valid) chk("cmp_instr", bus.instr, m_instr);
        chk("cmp_pc", bus.pc, m_pc);
        chk("cmp_pc4", bus.pc_plus4, m_pc + 32'd4);
        chk("cmp_align", {31'd0, bus.align_err}, {31'd0, m_align});
        chk("cmp_retired", bus.retired, m_ret);
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.instr_valid === 1'b1) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_valid timeout actual=0 required=1");
        end
    endtask

    // Acknowledge the presented instruction, then check the next fetch address.
    task automatic step(input string name, input logic [1:0] sel, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] jr, input logic [31:0] exp_addr);
        wait_valid();
        bus.sm5 = sel; bus.imm16 = imm; bus.target26 = tgt; bus.jr_addr = jr;
        bus.instr_ack = 1'b1;
        @(posedge clk); #1;
        bus.instr_ack = 1'b0;
        chk({name, "_req"}, {31'd0, bus.imem_req}, 32'd1);
        chk(name, bus.imem_addr, exp_addr);
    endtask

    initial begin
        bus.sm5 = 0; bus.imm16 = 0; bus.target26 = 0; bus.jr_addr = 0;
        bus.halt = 0; bus.instr_ack = 0; bus.imem_ready = 1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pc", bus.pc, RPC);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);

        // sequential fetch
        step("seq4", 2'd0, 16'h0, 26'h0, 32'h0, 32'h4);
        step("seq8", 2'd0, 16'h0, 26'h0, 32'h0, 32'h8);
        step("seqC", 2'd0, 16'h0, 26'h0, 32'h0, 32'hC);
        chk("retired3", bus.retired, 32'd3);

        // branches
        step("jr40", 2'd3, 16'h0, 26'h0, 32'h40, 32'h40);
        step("br_back", 2'd1, 16'hFFFE, 26'h0, 32'h0, 32'h3C);
        step("br_fwd", 2'd1, 16'h0003, 26'h0, 32'h0, 32'h4C);

        // jump keeps the upper nibble of pc+4
        step("jrA0", 2'd3, 16'h0, 26'h0, 32'hA000_0010, 32'hA000_0010);
        wait_valid();
        chk("jal_link", bus.pc_plus4, 32'hA000_0014);
        step("jump", 2'd2, 16'h0, 26'h000_0100, 32'h0, 32'hA000_0400);

        // misaligned jr is forced to a word and sticks the flag
        step("jr_mis", 2'd3, 16'h0, 26'h0, 32'h0000_1236, 32'h0000_1234);
        chk("align_set", {31'd0, bus.align_err}, 32'd1);
        step("jr8", 2'd3, 16'h0, 26'h0, 32'h8, 32'h8);
        chk("align_sticky", {31'd0, bus.align_err}, 32'd1);
        chk("retired10", bus.retired, 32'd10);

        // ack with halt
        wait_valid();
        bus.sm5 = 2'd0; bus.halt = 1'b1; bus.instr_ack = 1'b1;
        @(posedge clk); #1;
        bus.instr_ack = 1'b0; bus.halt = 1'b0;
        chk("halt_retired", bus.retired, 32'd11);
        chk("halt_pc", bus.pc, 32'hC);
        for (int i = 0; i < 10; i++) begin
            bus.instr_ack = (i % 2 == 0);
            bus.halt = (i % 3 == 0);
            @(posedge clk); #1;
            chk("halted_req", {31'd0, bus.imem_req}, 32'd0);
            chk("halted_retired", bus.retired, 32'd11);
        end
        bus.instr_ack = 0; bus.halt = 0;

        // stalled fetch, then asynchronous reset mid-request
        rst = 1'b0;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("stall_req", {31'd0, bus.imem_req}, 32'd1);
            chk("stall_addr", bus.imem_addr, RPC);
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_req", {31'd0, bus.imem_req}, 32'd0);
        chk("async_pc", bus.pc, RPC);
        chk("async_retired", bus.retired, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.imem_ready = 1'b1;
        step("re_seq4", 2'd0, 16'h0, 26'h0, 32'h0, 32'h4);
        step("re_seq8", 2'd0, 16'h0, 26'h0, 32'h0, 32'h8);
        chk("re_align", {31'd0, bus.align_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
